// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX framer and the future RX checker.
//   - parity mode codes (3-bit; codes 5..7 behave as "none")
//   - frame state encoding
//   - parity helpers operating on a zero-extended data word
package uart_pkg;

    localparam int MAX_DATA_W = 9;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // True when the mode inserts a parity bit; reserved codes act as none.
    function automatic logic has_parity(input logic [2:0] mode);
        return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
    endfunction

    // Zero-extension of narrower words does not change the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic [2:0]            mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter shared by the UART transmitter and receiver.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count while high
//   load      - restart a full bit period (takes priority over en)
//   bit_tick  - one-cycle pulse on the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_tick = en && !load && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en) begin
            // Reload on the terminal count so consecutive bits stay exact.
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional
// parity bit, then one or two stop bits.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   tx_data, tx_valid   - word to send and its valid (sampled on accept)
//   tx_ready            - high only in IDLE
//   parity_mode, stop2  - frame format, sampled on accept
//   txd                 - serial line, idle high, registered
//   busy                - frame in progress
//   frame_done          - pulse on the final cycle of the last stop bit
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [2:0]        parity_mode,
    input  logic              stop2,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int BCW = $clog2(DATA_W) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    uart_state_t       state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              txd_q, txd_d;
    logic              timer_load;
    logic              bit_tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .en      (state_q != IDLE),
        .load    (timer_load),
        .bit_tick(bit_tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign txd      = txd_q;

    // txd_d is the line value for the next cycle, so every bit change lands
    // one cycle after the tick that ends the previous bit.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        timer_load = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (tx_valid) begin
                    state_d    = START;
                    txd_d      = 1'b0;
                    sh_d       = tx_data;
                    par_en_d   = has_parity(parity_mode);
                    par_bit_d  = parity_bit(MAX_DATA_W'(tx_data), parity_mode);
                    stop2_d    = stop2;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    timer_load = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    txd_d     = sh_q[0];
                    sh_d      = sh_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        txd_d     = sh_q[0];
                        sh_d      = sh_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    // stop_cnt counts completed stop bits: 0 ends a 1-stop
                    // frame, 1 ends a 2-stop frame.
                    if (stop_cnt_q == stop2_q) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
        end
    end

endmodule
